// File: rtl/preproc_modexp.sv
// preproc_modexp: serial (m * 2^k) mod n using one shift/subtract step per cycle.
// Optional PREPROC_CYCLE_CNT_EN adds a saturating busy-cycle counter output.
`default_nettype none

module preproc_modexp #(
  parameter int WIDTH = 256,
  parameter int KW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] n,
  input  logic [KW-1:0]    k,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             err
`ifdef PREPROC_CYCLE_CNT_EN
  ,
  output logic [31:0]      cycles
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REDUCE = 2'd1;
  localparam logic [1:0] DOUBLE = 2'd2;
  localparam logic [1:0] FIN    = 2'd3;

  // Counter must hold both the bit index (WIDTH-1) and the doubling count (k-1), plus headroom.
  localparam int CW = (KW > $clog2(WIDTH)) ? KW + 1 : $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] m_sh;
  logic [WIDTH-1:0] n_r;
  logic [KW-1:0]    k_r;
  logic [WIDTH-1:0] r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   step_val;
  logic [WIDTH:0]   n_ext;
  logic [WIDTH-1:0] r_next;
  logic             accept;
  logic             last_bit;
  logic             last_dbl;

  assign accept   = (state == IDLE) && start;
  assign n_ext    = {1'b0, n_r};
  assign step_val = (state == REDUCE) ? {r, m_sh[WIDTH-1]} : {r, 1'b0};
  // step_val < 2n, so a single conditional subtract restores r < n.
  assign r_next   = (step_val >= n_ext) ? WIDTH'(step_val - n_ext) : WIDTH'(step_val);
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign last_dbl = ((cnt + CW'(1)) == CW'(k_r));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m_sh  <= '0;
      n_r   <= '0;
      k_r   <= '0;
      r     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_sh <= m;
            n_r  <= n;
            k_r  <= k;
            r    <= '0;
            cnt  <= '0;
            busy <= 1'b1;
            if (n != '0) begin
              err   <= 1'b0;
              state <= REDUCE;
            end else begin
              state <= FIN;
            end
          end
        end
        REDUCE: begin
          r    <= r_next;
          m_sh <= {m_sh[WIDTH-2:0], 1'b0};
          if (last_bit) begin
            cnt   <= '0;
            state <= (k_r == '0) ? FIN : DOUBLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DOUBLE: begin
          r <= r_next;
          if (last_dbl) begin
            cnt   <= '0;
            state <= FIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          out   <= (n_r == '0) ? '0 : r;
          err   <= (n_r == '0);
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PREPROC_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles <= '0;
    end else if (accept) begin
      cycles <= '0;
    end else if (((state == REDUCE) || (state == DOUBLE)) && (cycles != 32'hFFFF_FFFF)) begin
      cycles <= cycles + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_preproc_modexp.sv
// Scoreboard bench for preproc_modexp (WIDTH=8): random and directed runs vs an arithmetic model.
`default_nettype none

module tb_preproc_modexp;

  localparam int WIDTH = 8;
  localparam int KW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] m = '0;
  logic [WIDTH-1:0] n = '0;
  logic [KW-1:0]    k = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             err;
`ifdef PREPROC_CYCLE_CNT_EN
  logic [31:0]      cycles;
`endif

  preproc_modexp #(.WIDTH(WIDTH), .KW(KW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .m     (m),
    .n     (n),
    .k     (k),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .err   (err)
`ifdef PREPROC_CYCLE_CNT_EN
    ,
    .cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint exp_out;
    longint exp_err;
    int     acc;
    int     lat;
    int     exp_cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint expv);
    tests++;
    if (act != expv) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out", longint'(out), e.exp_out);
        chk("err", longint'(err), e.exp_err);
        chk("latency", longint'(cyc - e.acc), longint'(e.lat));
`ifdef PREPROC_CYCLE_CNT_EN
        if (e.exp_cyc >= 0) chk("cycles", longint'(cycles), longint'(e.exp_cyc));
`endif
      end
    end
  end

  function automatic longint ref_mod(input longint mm, input longint nn, input int kk);
    if (nn == 0) return 0;
    return (mm << kk) % nn;
  endfunction

  // Issue one request; optionally pulse start again at edge 3 after acceptance.
  task automatic issue(input logic [WIDTH-1:0] mi, input logic [WIDTH-1:0] ni,
                       input logic [KW-1:0] ki, input bit extra);
    exp_t e;
    int   d0;
    bit   bad_busy;
    e.exp_out = ref_mod(longint'(mi), longint'(ni), int'(ki));
    e.exp_err = (ni == 0) ? 1 : 0;
    e.acc     = cyc + 1;
    e.lat     = (ni == 0) ? 1 : WIDTH + int'(ki) + 1;
    e.exp_cyc = (ni == 0) ? -1 : WIDTH + int'(ki);
    q.push_back(e);
    m = mi; n = ni; k = ki; start = 1'b1;
    d0 = done_cnt;
    @(negedge clk); #1;
    start = 1'b0;
    m = WIDTH'($urandom); n = WIDTH'($urandom); k = KW'($urandom);
    bad_busy = 1'b0;
    for (int c = 0; c < 200 && done_cnt == d0; c++) begin
      if (!busy) bad_busy = 1'b1;
      start = (extra && c == 2);
      @(negedge clk); #1;
    end
    start = 1'b0;
    if (done_cnt == d0) begin
      tests++;
      failed++;
      $display("FAIL timeout: got no done expected done within 200 cycles (m=%0h n=%0h k=%0d)", mi, ni, ki);
    end
    chk("busy_during_run", longint'(bad_busy), 0);
    chk("busy_at_done", longint'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_out", longint'(out), 0);
    chk("rst_err", longint'(err), 0);
`ifdef PREPROC_CYCLE_CNT_EN
    chk("rst_cycles", longint'(cycles), 0);
`endif
    rst = 1'b0;
    @(negedge clk); #1;

    issue(8'h05, 8'h07, 4'd8, 1'b0);
    issue(8'hFF, 8'h0D, 4'd0, 1'b0);
    issue(8'h01, 8'hFB, 4'd8, 1'b1);
    issue(8'h5A, 8'h00, 4'd3, 1'b0);
    issue(8'h03, 8'h07, 4'd1, 1'b0);
    issue(8'hC3, 8'h11, 4'd4, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] rm, rn;
      int sel;
      sel = $urandom_range(0, 9);
      rm  = WIDTH'($urandom);
      rn  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h01 : WIDTH'($urandom);
      issue(rm, rn, KW'($urandom_range(0, 15)), 1'b0);
    end

    issue(8'h05, 8'h07, 4'd8, 1'b0);
    // Abandon a k=8 run with reset at edge 5 after acceptance; no done may follow.
    m = 8'h09; n = 8'h0B; k = 4'd8; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_out", longint'(out), 0);
    chk("midrst_done", longint'(done), 0);
    repeat (25) @(negedge clk);
    #1;
    issue(8'h05, 8'h07, 4'd8, 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_empty", longint'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/preproc_modexp.md
PREPROC_MODEXP -- requirements
Module: preproc_modexp

Interface
REQ-001 SHALL have parameter WIDTH, default 256, giving the operand and result width in bits (WIDTH >= 4).
REQ-002 SHALL have parameter KW, default 9, giving the width of the shift-count input.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a computation; sampled only in IDLE.
REQ-006 SHALL have port m  input  WIDTH  multiplicand.
REQ-007 SHALL have port n  input  WIDTH  modulus.
REQ-008 SHALL have port k  input  KW  shift count; any value 0..2^KW-1 is legal.
REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking the result as valid.
REQ-011 SHALL have port out  output  WIDTH  result, (m * 2^k) mod n.
REQ-012 SHALL have port err  output  1  high with done when n == 0.

Function
REQ-013 SHALL have states IDLE, REDUCE, DOUBLE and FIN.
REQ-014 SHALL, in IDLE with start=1 at a clock edge:
 - capture m, n and k into internal registers;
 - go to REDUCE;
 - clear the residue r.
REQ-015 SHALL perform exactly one step per cycle in REDUCE, taking m bits MSB-first:
 - r = 2r + m[i];
 - if r >= n then r = r - n;
 - WIDTH steps, then go to DOUBLE, or go to FIN if k == 0.
REQ-016 SHALL perform exactly one step per cycle in DOUBLE:
 - r = 2r;
 - if r >= n then r = r - n;
 - k steps, then go to FIN.
REQ-017 SHALL compute intermediate 2r and 2r+bit at WIDTH+1 bits, so no overflow is lost; r < n always holds after each step.
REQ-018 SHALL, in FIN:
 - drive done=1 for exactly one cycle;
 - load out with r;
 - return to IDLE.
REQ-019 SHALL assert done exactly WIDTH+k+1 edges after the edge that accepted start.
REQ-020 SHALL, if captured n == 0:
 - skip REDUCE and DOUBLE and go directly to FIN;
 - set out=0 and err=1 with done, i.e. 1 edge after acceptance.
REQ-021 SHALL clear err at the next accepted start that has n != 0.
REQ-022 SHALL hold out and err stable between done pulses.
REQ-023 SHALL ignore start while busy=1, and SHALL ignore changes on m, n and k after capture.
REQ-024 SHALL accept start in the IDLE cycle immediately following FIN (back-to-back operation).
REQ-025 SHALL yield out=0 for n == 1, and out=m mod n for k == 0.

Reset
REQ-026 SHALL, with rst=1 at a clock edge:
 - enter IDLE;
 - clear busy, done, err, out and r to 0;
 - clear the step counter to 0.
REQ-027 SHALL, on rst mid-operation, abandon the computation without producing a done pulse.
REQ-028 SHALL, with rst=1 and start=1 at the same edge, give reset priority.

Configuration
REQ-029 SHALL, when macro PREPROC_CYCLE_CNT_EN is defined:
 - add output cycles [31:0], reset to 0;
 - clear it on start acceptance;
 - increment it each edge while busy, saturating at 0xFFFFFFFF;
 - hold it after done.
REQ-030 SHALL, without PREPROC_CYCLE_CNT_EN, omit the cycles port and its logic, with all other behaviour identical.

Verification
REQ-031 SHALL cover: WIDTH=8, m=0x05, n=0x07, k=8 -> out=0x06, err=0, done 17 edges after acceptance.
REQ-032 SHALL cover: WIDTH=8, m=0xFF, n=0x0D, k=0 -> out=0x08, done 9 edges after acceptance.
REQ-033 SHALL cover: WIDTH=8, m=0x01, n=0xFB, k=8 -> out=0x05; a second start pulse at edge 3 is ignored; busy stays high until done.
REQ-034 SHALL cover: n=0x00, any m and k -> done 1 edge after acceptance, out=0, err=1; the next start with n=0x07, m=0x03, k=1 -> out=0x06, err=0.
REQ-035 SHALL cover: rst=1 at edge 5 of a k=8 run -> IDLE, busy=0, out=0, no done pulse; a following start completes normally.
REQ-036 SHALL cover, with PREPROC_CYCLE_CNT_EN: WIDTH=8, k=4 -> cycles=12 at done.
